// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer_if
// Purpose : control/status bundle between the instruction sequencer and the
//           datapath plus memory port.
// Rev     : 1.0
// ============================================================================
interface instr_sequencer_if;
  logic        Run;
  logic [31:0] IR;
  logic        MemAck;
  logic        BrTaken;

  logic        IR_E;
  logic        PC_E;
  logic [1:0]  PC_Sel;
  logic        Addr_Sel;
  logic        MemReq;
  logic        W;
  logic        RF_E;
  logic [1:0]  WB_Sel;
  logic        SrcB_Imm;
  logic [2:0]  ALUOp;
  logic        Alt;
  logic [2:0]  Imm_Sel;
  logic        Done;
  logic        Illegal;
  logic [2:0]  State;

  modport master (
    input  Run, IR, MemAck, BrTaken,
    output IR_E, PC_E, PC_Sel, Addr_Sel, MemReq, W, RF_E, WB_Sel,
           SrcB_Imm, ALUOp, Alt, Imm_Sel, Done, Illegal, State
  );

  modport slave (
    output Run, IR, MemAck, BrTaken,
    input  IR_E, PC_E, PC_Sel, Addr_Sel, MemReq, W, RF_E, WB_Sel,
           SrcB_Imm, ALUOp, Alt, Imm_Sel, Done, Illegal, State
  );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : instr_sequencer
// Purpose : multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/trap).
// Rev     : 1.0
// ============================================================================
module instr_sequencer #(
  parameter int XLEN      = 32,
  parameter bit TRAP_HOLD = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("instr_sequencer supports XLEN=32 only");
    end
  endgenerate

  state_t state_q, state_d;
  state_t boundary;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       rd_nz;
  logic       unused_ir;

  assign opcode    = bus.IR[6:0];
  assign funct3    = bus.IR[14:12];
  assign funct7    = bus.IR[31:25];
  assign rd_nz     = (bus.IR[11:7] != 5'd0);
  assign unused_ir = ^bus.IR[24:15];

  // Next state once an instruction retires: Run is only looked at here.
  assign boundary  = bus.Run ? S_FETCH : S_IDLE;

  logic is_r, is_i, is_lw, is_sw, is_br, is_lui, is_jal, is_jalr, legal;

  always_comb begin
    is_r    = (opcode == OP_R) && ((funct7 == F7_BASE) || (funct7 == F7_ALT));
    is_i    = 1'b0;
    if (opcode == OP_IMM) begin
      case (funct3)
        3'b001:  is_i = (funct7 == F7_BASE);
        3'b101:  is_i = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        default: is_i = 1'b1;
      endcase
    end
    is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
    is_sw   = (opcode == OP_STORE)  && (funct3 == 3'b010);
    is_br   = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
    is_lui  = (opcode == OP_LUI);
    is_jal  = (opcode == OP_JAL);
    is_jalr = (opcode == OP_JALR)   && (funct3 == 3'b000);
    legal   = is_r | is_i | is_lw | is_sw | is_br | is_lui | is_jal | is_jalr;
  end

  logic       cls_srcb;
  logic [2:0] cls_op;
  logic       cls_alt;
  logic [2:0] cls_imm;
  logic [1:0] cls_wb_sel;
  logic [1:0] cls_wb_pc_sel;

  // Per-instruction datapath steering, held stable from EXEC through WB.
  always_comb begin
    cls_srcb      = !(is_r || is_br);
    cls_op        = (is_r || is_i) ? funct3 : 3'b000;
    cls_alt       = bus.IR[30] && (is_r || (is_i && (funct3 == 3'b101)));
    cls_imm       = is_sw  ? 3'd1 :
                    is_br  ? 3'd2 :
                    is_lui ? 3'd3 :
                    is_jal ? 3'd4 : 3'd0;
    cls_wb_sel    = is_lw               ? 2'd1 :
                    (is_jal || is_jalr) ? 2'd2 :
                    is_lui              ? 2'd3 : 2'd0;
    cls_wb_pc_sel = is_jal  ? 2'd1 :
                    is_jalr ? 2'd2 : 2'd0;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  logic       ir_e, pc_e, addr_sel, mem_req, w, rf_e, srcb_imm, alt, done, illegal;
  logic       drive_alu;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] alu_op, imm_sel, state_o;

  always_comb begin
    state_d   = state_q;
    ir_e      = 1'b0;
    pc_e      = 1'b0;
    pc_sel    = 2'd0;
    addr_sel  = 1'b0;
    mem_req   = 1'b0;
    w         = 1'b0;
    rf_e      = 1'b0;
    wb_sel    = 2'd0;
    srcb_imm  = 1'b0;
    alu_op    = 3'd0;
    alt       = 1'b0;
    imm_sel   = 3'd0;
    done      = 1'b0;
    illegal   = 1'b0;
    drive_alu = 1'b0;
    state_o   = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.MemAck) begin
          ir_e    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        drive_alu = 1'b1;
        if (is_br) begin
          pc_e    = 1'b1;
          pc_sel  = bus.BrTaken ? 2'd1 : 2'd0;
          done    = 1'b1;
          state_d = boundary;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        drive_alu = 1'b1;
        mem_req   = 1'b1;
        addr_sel  = 1'b1;
        w         = is_sw;
        if (bus.MemAck) begin
          if (is_sw) begin
            pc_e    = 1'b1;
            done    = 1'b1;
            state_d = boundary;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        drive_alu = 1'b1;
        rf_e      = rd_nz;
        wb_sel    = cls_wb_sel;
        pc_e      = 1'b1;
        pc_sel    = cls_wb_pc_sel;
        done      = 1'b1;
        state_d   = boundary;
      end
      S_TRAP: begin
        illegal = 1'b1;
        if (!TRAP_HOLD) begin
          pc_e    = 1'b1;
          state_d = boundary;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (drive_alu) begin
      srcb_imm = cls_srcb;
      alu_op   = cls_op;
      alt      = cls_alt;
      imm_sel  = cls_imm;
    end

    // An instruction caught by reset must not commit anything in that cycle.
    if (!Resetn) begin
      ir_e     = 1'b0;
      pc_e     = 1'b0;
      pc_sel   = 2'd0;
      addr_sel = 1'b0;
      mem_req  = 1'b0;
      w        = 1'b0;
      rf_e     = 1'b0;
      wb_sel   = 2'd0;
      srcb_imm = 1'b0;
      alu_op   = 3'd0;
      alt      = 1'b0;
      imm_sel  = 3'd0;
      done     = 1'b0;
      illegal  = 1'b0;
      state_o  = 3'd0;
    end
  end

  assign bus.IR_E     = ir_e;
  assign bus.PC_E     = pc_e;
  assign bus.PC_Sel   = pc_sel;
  assign bus.Addr_Sel = addr_sel;
  assign bus.MemReq   = mem_req;
  assign bus.W        = w;
  assign bus.RF_E     = rf_e;
  assign bus.WB_Sel   = wb_sel;
  assign bus.SrcB_Imm = srcb_imm;
  assign bus.ALUOp    = alu_op;
  assign bus.Alt      = alt;
  assign bus.Imm_Sel  = imm_sel;
  assign bus.Done     = done;
  assign bus.Illegal  = illegal;
  assign bus.State    = state_o;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_sequencer
// Purpose : table-driven and randomized checks of instr_sequencer against a
//           per-instruction cycle-script reference model.
// Rev     : 1.0
// ============================================================================
module tb_instr_sequencer;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  instr_sequencer_if bus();

  instr_sequencer #(.XLEN(32), .TRAP_HOLD(1'b1)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_LUI, K_JAL, K_JALR, K_BAD} kind_t;

  typedef struct packed {
    logic       ir_e;
    logic       pc_e;
    logic [1:0] pc_sel;
    logic       addr_sel;
    logic       mem_req;
    logic       w;
    logic       rf_e;
    logic [1:0] wb_sel;
    logic       srcb_imm;
    logic [2:0] alu_op;
    logic       alt;
    logic [2:0] imm_sel;
    logic       done;
    logic       illegal;
    logic [2:0] state;
  } outs_t;

  typedef struct packed {
    outs_t exp;
    logic  ack;
  } step_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        br;
    int          fw;
    int          mw;
    logic        run_end;
    int          exp_len;
    int          exp_w;
    logic        exp_rf;
  } vec_t;

  step_t plan[$];
  vec_t  vec[$];
  int    vectors     = 0;
  int    miscompares = 0;
  bit    idle        = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic outs_t capture();
    outs_t o;
    o.ir_e     = bus.IR_E;
    o.pc_e     = bus.PC_E;
    o.pc_sel   = bus.PC_Sel;
    o.addr_sel = bus.Addr_Sel;
    o.mem_req  = bus.MemReq;
    o.w        = bus.W;
    o.rf_e     = bus.RF_E;
    o.wb_sel   = bus.WB_Sel;
    o.srcb_imm = bus.SrcB_Imm;
    o.alu_op   = bus.ALUOp;
    o.alt      = bus.Alt;
    o.imm_sel  = bus.Imm_Sel;
    o.done     = bus.Done;
    o.illegal  = bus.Illegal;
    o.state    = bus.State;
    return o;
  endfunction

  // Instruction class straight from the supported-encoding list.
  function automatic kind_t klass(input logic [31:0] ir);
    logic [2:0] f3;
    logic [6:0] f7;
    bit         f7ok;
    f3   = ir[14:12];
    f7   = ir[31:25];
    f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    case (ir[6:0])
      7'h33: return f7ok ? K_R : K_BAD;
      7'h13: begin
        if (f3 == 3'd1)      return (f7 == 7'h00) ? K_I : K_BAD;
        else if (f3 == 3'd5) return f7ok ? K_I : K_BAD;
        else                 return K_I;
      end
      7'h03: return (f3 == 3'd2) ? K_LW : K_BAD;
      7'h23: return (f3 == 3'd2) ? K_SW : K_BAD;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_BAD : K_BR;
      7'h37: return K_LUI;
      7'h6F: return K_JAL;
      7'h67: return (f3 == 3'd0) ? K_JALR : K_BAD;
      default: return K_BAD;
    endcase
  endfunction

  function automatic outs_t alu_ctl(input kind_t k, input logic [31:0] ir);
    outs_t a;
    a = '0;
    case (k)
      K_R:    begin a.alu_op = ir[14:12]; a.alt = ir[30]; end
      K_I:    begin a.srcb_imm = 1'b1; a.alu_op = ir[14:12]; a.alt = (ir[14:12] == 3'd5) && ir[30]; end
      K_LW:   a.srcb_imm = 1'b1;
      K_SW:   begin a.srcb_imm = 1'b1; a.imm_sel = 3'd1; end
      K_BR:   a.imm_sel = 3'd2;
      K_LUI:  begin a.srcb_imm = 1'b1; a.imm_sel = 3'd3; end
      K_JAL:  begin a.srcb_imm = 1'b1; a.imm_sel = 3'd4; end
      K_JALR: a.srcb_imm = 1'b1;
      default: ;
    endcase
    return a;
  endfunction

  function automatic void push(input outs_t e, input logic ack);
    step_t s;
    s.exp = e;
    s.ack = ack;
    plan.push_back(s);
  endfunction

  // Expected per-cycle script for one instruction, starting in fetch.
  function automatic void build_plan(input logic [31:0] ir, input logic br, input int fw, input int mw);
    kind_t k;
    outs_t a, e;
    k = klass(ir);
    a = alu_ctl(k, ir);
    plan.delete();
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.state = 3'd1; e.mem_req = 1'b1; e.ir_e = (i == fw);
      push(e, i == fw);
    end
    e = '0; e.state = 3'd2;
    push(e, 1'b0);
    if (k == K_BAD) begin
      e = '0; e.state = 3'd6; e.illegal = 1'b1;
      push(e, 1'b0);
      return;
    end
    e = a; e.state = 3'd3;
    if (k == K_BR) begin
      e.pc_e = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0; e.done = 1'b1;
      push(e, 1'b0);
      return;
    end
    push(e, 1'b0);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mw; i++) begin
        e = a; e.state = 3'd4; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.w = (k == K_SW);
        if (k == K_SW && i == mw) begin e.pc_e = 1'b1; e.done = 1'b1; end
        push(e, i == mw);
      end
    end
    if (k != K_SW) begin
      e = a; e.state = 3'd5; e.rf_e = (ir[11:7] != 5'd0); e.pc_e = 1'b1; e.done = 1'b1;
      e.wb_sel = (k == K_LW) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : (k == K_LUI) ? 2'd3 : 2'd0;
      e.pc_sel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
      push(e, 1'b0);
    end
  endfunction

  task automatic cycle(input logic ack, input logic run, input logic rstn, input outs_t exp, input string name);
    bus.MemAck = ack;
    bus.Run    = run;
    Resetn     = rstn;
    @(negedge Clock);
    check(name, 32'(capture()), 32'(exp));
    @(posedge Clock);
    #1;
  endtask

  task automatic start();
    cycle(1'b0, 1'b1, 1'b1, '0, "idle_to_fetch");
    idle = 1'b0;
  endtask

  task automatic run_instr(input string name, input logic [31:0] ir, input logic br, input int fw,
                           input int mw, input logic run_end,
                           output int obs_len, output int obs_w, output logic obs_rf);
    outs_t o;
    bit    seen;
    bus.IR      = ir;
    bus.BrTaken = br;
    build_plan(ir, br, fw, mw);
    obs_len = 0; obs_w = 0; obs_rf = 1'b0; seen = 1'b0;
    foreach (plan[i]) begin
      bus.MemAck = plan[i].ack;
      bus.Run    = (i >= 1) ? run_end : 1'b1;
      Resetn     = 1'b1;
      @(negedge Clock);
      o = capture();
      check(name, 32'(o), 32'(plan[i].exp));
      if (!seen) obs_len++;
      if (o.done || o.illegal) seen = 1'b1;
      obs_w  += int'(o.w);
      obs_rf |= o.rf_e;
      @(posedge Clock);
      #1;
    end
    if (!seen) obs_len = 0;
  endtask

  task automatic trap_and_reset();
    outs_t t;
    t = '0; t.state = 3'd6; t.illegal = 1'b1;
    for (int i = 0; i < 3; i++) cycle(i[0], 1'b1, 1'b1, t, "trap_hold");
    cycle(1'b0, 1'b0, 1'b0, '0, "trap_reset_cycle");
    cycle(1'b0, 1'b0, 1'b1, '0, "trap_after_reset");
    idle = 1'b1;
  endtask

  task automatic finish_instr(input logic [31:0] ir, input logic run_end);
    if (klass(ir) == K_BAD) begin
      trap_and_reset();
    end else if (!run_end) begin
      cycle(1'b0, 1'b0, 1'b1, '0, "idle_after_stop");
      idle = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  ops [9];
    logic [31:0] ir;
    logic        br, run_end, obs_rf;
    int          fw, mw, idx, obs_len, obs_w;

    vec.push_back('{"add",       32'h002081B3, 1'b0, 0, 0, 1'b1, 4, 0, 1'b1});
    vec.push_back('{"lw_wait3",  32'h0080A283, 1'b0, 0, 3, 1'b1, 8, 0, 1'b1});
    vec.push_back('{"sw",        32'h0020A423, 1'b0, 0, 0, 1'b1, 4, 1, 1'b0});
    vec.push_back('{"sw_wait2",  32'h0020A423, 1'b0, 1, 2, 1'b1, 7, 3, 1'b0});
    vec.push_back('{"beq_taken", 32'h00208463, 1'b1, 0, 0, 1'b1, 3, 0, 1'b0});
    vec.push_back('{"beq_not",   32'h00208463, 1'b0, 2, 0, 1'b1, 5, 0, 1'b0});
    vec.push_back('{"addi_x0",   32'h00100013, 1'b0, 0, 0, 1'b1, 4, 0, 1'b0});
    vec.push_back('{"lui",       32'h123452B7, 1'b0, 0, 0, 1'b1, 4, 0, 1'b1});
    vec.push_back('{"jal",       32'h008000EF, 1'b0, 0, 0, 1'b1, 4, 0, 1'b1});
    vec.push_back('{"jalr",      32'h000100E7, 1'b0, 0, 0, 1'b1, 4, 0, 1'b1});
    vec.push_back('{"srai",      32'h40315093, 1'b0, 0, 0, 1'b1, 4, 0, 1'b1});
    vec.push_back('{"lw_stop",   32'h0080A283, 1'b0, 0, 1, 1'b0, 6, 0, 1'b1});
    vec.push_back('{"ill_ones",  32'hFFFFFFFF, 1'b0, 0, 0, 1'b1, 3, 0, 1'b0});
    vec.push_back('{"ill_slli",  32'h40311093, 1'b0, 0, 0, 1'b1, 3, 0, 1'b0});
    vec.push_back('{"ill_lb",    32'h00008283, 1'b0, 1, 0, 1'b1, 4, 0, 1'b0});
    vec.push_back('{"ill_br010", 32'h0020A463, 1'b0, 0, 0, 1'b1, 3, 0, 1'b0});
    vec.push_back('{"ill_jalr1", 32'h000110E7, 1'b0, 0, 0, 1'b1, 3, 0, 1'b0});

    bus.IR = '0; bus.Run = 1'b0; bus.MemAck = 1'b0; bus.BrTaken = 1'b0; Resetn = 1'b0;
    @(posedge Clock);
    #1;
    cycle(1'b0, 1'b0, 1'b0, '0, "reset");
    cycle(1'b1, 1'b0, 1'b1, '0, "idle_ack_ignored");
    cycle(1'b0, 1'b0, 1'b1, '0, "idle_hold");
    idle = 1'b1;

    foreach (vec[i]) begin
      if (idle) start();
      run_instr(vec[i].name, vec[i].ir, vec[i].br, vec[i].fw, vec[i].mw, vec[i].run_end,
                obs_len, obs_w, obs_rf);
      check({vec[i].name, "_latency"}, obs_len, vec[i].exp_len);
      check({vec[i].name, "_w_cycles"}, obs_w, vec[i].exp_w);
      check({vec[i].name, "_rf_e"}, {31'd0, obs_rf}, {31'd0, vec[i].exp_rf});
      finish_instr(vec[i].ir, vec[i].run_end);
    end

    // Reset arriving while a store waits in MEM: no write may escape.
    if (idle) start();
    bus.IR = 32'h0020A423; bus.BrTaken = 1'b0;
    build_plan(32'h0020A423, 1'b0, 0, 5);
    for (int i = 0; i < 4; i++) cycle(plan[i].ack, 1'b1, 1'b1, plan[i].exp, "sw_before_reset");
    cycle(1'b0, 1'b1, 1'b0, '0, "reset_in_mem");
    cycle(1'b0, 1'b0, 1'b1, '0, "idle_after_mem_reset");
    idle = 1'b1;

    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h67, 7'h00};
    for (int n = 0; n < 150; n++) begin
      ir  = $urandom;
      idx = $urandom_range(0, 8);
      if (idx != 8) ir[6:0] = ops[idx];
      case ($urandom_range(0, 3))
        0:       ir[31:25] = 7'h00;
        1:       ir[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        if (ir[6:0] == 7'h03 || ir[6:0] == 7'h23) ir[14:12] = 3'd2;
        else if (ir[6:0] == 7'h67)                ir[14:12] = 3'd0;
      end
      br      = 1'($urandom_range(0, 1));
      fw      = $urandom_range(0, 3);
      mw      = $urandom_range(0, 3);
      run_end = ($urandom_range(0, 3) != 0);
      if (idle) start();
      run_instr("random", ir, br, fw, mw, run_end, obs_len, obs_w, obs_rf);
      finish_instr(ir, run_end);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
